// File: rtl/laser_pkg.sv
`default_nettype none
// ============================================================================
// Module : laser_pkg
// Brief  : Shared types, sizes and distance helper for the LASER stimulus scorer.
// Rev    : 1.0  initial release
// ============================================================================
package laser_pkg;

    localparam int NPTS    = 40;
    localparam int COORD_W = 4;
    localparam int PTR_W   = 6;

    typedef struct packed {
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
    } point_t;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_RESET  = 3'd1,
        S_SEND   = 3'd2,
        S_RUN    = 3'd3,
        S_SCORE  = 3'd4,
        S_REPORT = 3'd5
    } state_e;

    // Squared euclidean distance; 9 bits holds the worst case 2*15^2 = 450.
    function automatic logic [2*COORD_W:0] dist2(
        input logic [COORD_W-1:0] px,
        input logic [COORD_W-1:0] py,
        input logic [COORD_W-1:0] cx,
        input logic [COORD_W-1:0] cy
    );
        logic [COORD_W-1:0]   dx;
        logic [COORD_W-1:0]   dy;
        logic [2*COORD_W-1:0] sx;
        logic [2*COORD_W-1:0] sy;
        dx = (px > cx) ? (px - cx) : (cx - px);
        dy = (py > cy) ? (py - cy) : (cy - py);
        sx = dx * dx;
        sy = dy * dy;
        return {1'b0, sx} + {1'b0, sy};
    endfunction

endpackage
`default_nettype wire

// File: rtl/laser_cover_unit.sv
`default_nettype none
// ============================================================================
// Module : laser_cover_unit
// Brief  : Combinational hit test - point lies within radius sqrt(R2) of either centre.
// Rev    : 1.0  initial release
// ============================================================================
module laser_cover_unit
    import laser_pkg::*;
#(
    parameter int R2 = 16
) (
    input  logic [COORD_W-1:0] i_px,
    input  logic [COORD_W-1:0] i_py,
    input  logic [COORD_W-1:0] i_c1x,
    input  logic [COORD_W-1:0] i_c1y,
    input  logic [COORD_W-1:0] i_c2x,
    input  logic [COORD_W-1:0] i_c2y,
    output logic               o_hit
);

    localparam logic [2*COORD_W:0] c_r2 = (2*COORD_W+1)'(R2);

    logic [2*COORD_W:0] w_d1;
    logic [2*COORD_W:0] w_d2;

    assign w_d1  = dist2(i_px, i_py, i_c1x, i_c1y);
    assign w_d2  = dist2(i_px, i_py, i_c2x, i_c2y);
    assign o_hit = (w_d1 <= c_r2) || (w_d2 <= c_r2);

endmodule
`default_nettype wire

// File: rtl/laser_stim_scorer.sv
`default_nettype none
// ============================================================================
// Module : laser_stim_scorer
// Brief  : Stores a 40-point pattern, drives it into LASER and scores the returned
//          centres by counting covered points. Optional RUN watchdog: LASER_TIMEOUT_EN.
// Rev    : 1.0  initial release
// ============================================================================
module laser_stim_scorer
    import laser_pkg::*;
#(
    parameter int RST_CYC    = 2,
    parameter int R2         = 16,
    parameter int CYC_W      = 16
`ifdef LASER_TIMEOUT_EN
    ,
    parameter int MAX_CYCLES = 50000
`endif
) (
    input  logic               clk,
    input  logic               rst,          // synchronous, active low
    input  logic               i_ld_valid,
    input  logic [COORD_W-1:0] i_ld_x,
    input  logic [COORD_W-1:0] i_ld_y,
    output logic               o_ld_ready,
    input  logic               i_ld_clr,
    input  logic               i_start,
    output logic               o_busy,
    output logic               o_dut_rst,
    output logic [COORD_W-1:0] o_x,
    output logic [COORD_W-1:0] o_y,
    input  logic               i_done,
    input  logic [COORD_W-1:0] i_c1x,
    input  logic [COORD_W-1:0] i_c1y,
    input  logic [COORD_W-1:0] i_c2x,
    input  logic [COORD_W-1:0] i_c2y,
    output logic               o_res_valid,
    output logic [5:0]         o_cover,
    output logic [CYC_W-1:0]   o_cycles,
    output logic               o_proto_err,
    output logic               o_timeout
);

    localparam logic [PTR_W-1:0] c_npts     = PTR_W'(NPTS);
    localparam logic [PTR_W-1:0] c_last_pt  = PTR_W'(NPTS - 1);
    localparam logic [PTR_W-1:0] c_rst_last = PTR_W'(RST_CYC - 1);

    state_e             r_state;
    point_t             r_buf [NPTS];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_idx;
    point_t             r_c1;
    point_t             r_c2;
    logic               r_dut_rst;
    logic [COORD_W-1:0] r_x;
    logic [COORD_W-1:0] r_y;
    logic               r_res_valid;
    logic [5:0]         r_cover;
    logic [CYC_W-1:0]   r_cycles;
    logic               r_proto_err;
    logic               r_timeout;

    logic               w_start_ok;
    logic               w_ld_fire;
    logic               w_hit;

    assign o_busy      = (r_state != S_IDLE);
    assign o_ld_ready  = (r_state == S_IDLE) && (r_wr_ptr < c_npts);
    assign w_start_ok  = (r_state == S_IDLE) && i_start && (r_wr_ptr == c_npts);
    assign w_ld_fire   = o_ld_ready && i_ld_valid && !i_ld_clr;

    assign o_dut_rst   = r_dut_rst;
    assign o_x         = r_x;
    assign o_y         = r_y;
    assign o_res_valid = r_res_valid;
    assign o_cover     = r_cover;
    assign o_cycles    = r_cycles;
    assign o_proto_err = r_proto_err;
    assign o_timeout   = r_timeout;

    laser_cover_unit #(
        .R2    (R2)
    ) u_cover (
        .i_px  (r_buf[r_idx].x),
        .i_py  (r_buf[r_idx].y),
        .i_c1x (r_c1.x),
        .i_c1y (r_c1.y),
        .i_c2x (r_c2.x),
        .i_c2y (r_c2.y),
        .o_hit (w_hit)
    );

    // Pattern storage carries no reset; contents are meaningless until reloaded.
    always_ff @(posedge clk) begin
        if (w_ld_fire) begin
            r_buf[r_wr_ptr] <= '{x: i_ld_x, y: i_ld_y};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_wr_ptr    <= '0;
            r_idx       <= '0;
            r_c1        <= '0;
            r_c2        <= '0;
            r_dut_rst   <= 1'b0;
            r_x         <= '0;
            r_y         <= '0;
            r_res_valid <= 1'b0;
            r_cover     <= '0;
            r_cycles    <= '0;
            r_proto_err <= 1'b0;
            r_timeout   <= 1'b0;
        end else begin
            r_res_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_start_ok) begin
                        r_state     <= S_RESET;
                        r_idx       <= '0;
                        r_dut_rst   <= 1'b1;
                        r_cover     <= '0;
                        r_cycles    <= '0;
                        r_proto_err <= 1'b0;
                        r_timeout   <= 1'b0;
                    end else if (i_ld_clr) begin
                        r_wr_ptr <= '0;
                    end else if (w_ld_fire) begin
                        r_wr_ptr <= r_wr_ptr + 1'b1;
                    end
                end
                S_RESET: begin
                    // Point 0 is presented on the same edge that releases LASER reset.
                    if (r_idx == c_rst_last) begin
                        r_state   <= S_SEND;
                        r_dut_rst <= 1'b0;
                        r_x       <= r_buf[0].x;
                        r_y       <= r_buf[0].y;
                        r_idx     <= PTR_W'(1);
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                S_SEND: begin
                    if (i_done) begin
                        r_proto_err <= 1'b1;
                        r_cover     <= '0;
                        r_x         <= '0;
                        r_y         <= '0;
                        r_res_valid <= 1'b1;
                        r_state     <= S_REPORT;
                    end else if (r_idx == c_npts) begin
                        r_x     <= '0;
                        r_y     <= '0;
                        r_state <= S_RUN;
                    end else begin
                        r_x   <= r_buf[r_idx].x;
                        r_y   <= r_buf[r_idx].y;
                        r_idx <= r_idx + 1'b1;
                    end
                end
                S_RUN: begin
                    if (i_done) begin
                        r_c1    <= '{x: i_c1x, y: i_c1y};
                        r_c2    <= '{x: i_c2x, y: i_c2y};
                        r_idx   <= '0;
                        r_state <= S_SCORE;
                    end
`ifdef LASER_TIMEOUT_EN
                    else if (r_cycles == CYC_W'(MAX_CYCLES)) begin
                        r_timeout <= 1'b1;
                        r_c1      <= '{x: i_c1x, y: i_c1y};
                        r_c2      <= '{x: i_c2x, y: i_c2y};
                        r_idx     <= '0;
                        r_state   <= S_SCORE;
                    end
`endif
                    else if (r_cycles != '1) begin
                        r_cycles <= r_cycles + 1'b1;
                    end
                end
                S_SCORE: begin
                    r_cover <= r_cover + {5'd0, w_hit};
                    if (r_idx == c_last_pt) begin
                        r_res_valid <= 1'b1;
                        r_state     <= S_REPORT;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                S_REPORT: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_laser_stim_scorer.sv
`default_nettype none
// ============================================================================
// Module : tb_laser_stim_scorer
// Brief  : Directed bench for laser_stim_scorer; LASER_TIMEOUT_EN adds a watchdog run.
// Rev    : 1.0  initial release
// ============================================================================
module tb_laser_stim_scorer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        i_ld_valid = 1'b0;
    logic [3:0]  i_ld_x = '0;
    logic [3:0]  i_ld_y = '0;
    logic        i_ld_clr = 1'b0;
    logic        i_start = 1'b0;
    logic        i_done = 1'b0;
    logic [3:0]  i_c1x = '0, i_c1y = '0, i_c2x = '0, i_c2y = '0;
    logic        o_ld_ready, o_busy, o_dut_rst, o_res_valid, o_proto_err, o_timeout;
    logic [3:0]  o_x, o_y;
    logic [5:0]  o_cover;
    logic [15:0] o_cycles;

    logic [3:0]  px [40];
    logic [3:0]  py [40];
    int          n_vec = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    laser_stim_scorer #(
        .CYC_W       (16)
`ifdef LASER_TIMEOUT_EN
        ,
        .MAX_CYCLES  (50)
`endif
    ) u_dut (
        .clk         (clk),
        .rst         (rst),
        .i_ld_valid  (i_ld_valid),
        .i_ld_x      (i_ld_x),
        .i_ld_y      (i_ld_y),
        .o_ld_ready  (o_ld_ready),
        .i_ld_clr    (i_ld_clr),
        .i_start     (i_start),
        .o_busy      (o_busy),
        .o_dut_rst   (o_dut_rst),
        .o_x         (o_x),
        .o_y         (o_y),
        .i_done      (i_done),
        .i_c1x       (i_c1x),
        .i_c1y       (i_c1y),
        .i_c2x       (i_c2x),
        .i_c2y       (i_c2y),
        .o_res_valid (o_res_valid),
        .o_cover     (o_cover),
        .o_cycles    (o_cycles),
        .o_proto_err (o_proto_err),
        .o_timeout   (o_timeout)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_pts(input int n);
        i_ld_clr = 1'b1;
        tick();
        i_ld_clr = 1'b0;
        for (int k = 0; k < n; k++) begin
            i_ld_valid = 1'b1;
            i_ld_x     = px[k];
            i_ld_y     = py[k];
            tick();
        end
        i_ld_valid = 1'b0;
    endtask

    task automatic set_c(input logic [3:0] ax, ay, bx, by);
        i_c1x = ax; i_c1y = ay; i_c2x = bx; i_c2y = by;
    endtask

    // done_cyc < 0: LASER never answers (watchdog build only).
    task automatic do_run(input int done_cyc);
        int lat;
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        chk("dut_rst_c0", o_dut_rst, 1);
        chk("busy_run", o_busy, 1);
        tick();
        chk("dut_rst_c1", o_dut_rst, 1);
        tick();
        chk("dut_rst_fall", o_dut_rst, 0);
        chk("xy_first", {o_x, o_y}, {px[0], py[0]});
        repeat (39) tick();
        chk("xy_last", {o_x, o_y}, {px[39], py[39]});
        tick();
        chk("xy_after_send", {o_x, o_y}, 8'h00);
        if (done_cyc >= 0) begin
            repeat (done_cyc) tick();
            i_done = 1'b1;
            tick();
            i_done = 1'b0;
        end
        lat = 0;
        while (!o_res_valid && lat < 400) begin
            tick();
            lat++;
        end
        chk("res_valid", o_res_valid, 1);
        if (done_cyc >= 0) chk("score_latency", lat, 40);
        tick();
        chk("res_pulse_one", o_res_valid, 0);
        chk("busy_end", o_busy, 0);
    endtask

    initial begin
        // Reset state
        repeat (3) tick();
        chk("rst_ld_ready", o_ld_ready, 1);
        chk("rst_busy", o_busy, 0);
        chk("rst_dut_rst", o_dut_rst, 0);
        chk("rst_xy", {o_x, o_y}, 8'h00);
        chk("rst_res", {o_res_valid, o_cover, o_proto_err, o_timeout}, 0);
        chk("rst_cycles", o_cycles, 0);
        rst = 1'b1;
        tick();

        // All points at (5,5); START with only 39 loaded is ignored
        for (int k = 0; k < 40; k++) begin px[k] = 4'd5; py[k] = 4'd5; end
        load_pts(39);
        chk("ready_39", o_ld_ready, 1);
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        chk("start_39_busy", o_busy, 0);
        i_ld_valid = 1'b1; i_ld_x = px[39]; i_ld_y = py[39];
        tick();
        i_ld_valid = 1'b0;
        chk("ready_full", o_ld_ready, 0);
        set_c(4'd5, 4'd5, 4'd0, 4'd0);
        do_run(100);
        chk("cover_all_in", o_cover, 40);
        chk("cycles_100", o_cycles, 100);
        chk("proto_clean", o_proto_err, 0);
        chk("timeout_clean", o_timeout, 0);
        tick();
        chk("cover_hold", o_cover, 40);

        // Same buffer re-run, centres far away: (5,5) to (0,0) is d^2=50
        set_c(4'd0, 4'd0, 4'd0, 4'd0);
        do_run(3);
        chk("cover_rerun_none", o_cover, 0);
        chk("cycles_3", o_cycles, 3);

        // Radius boundary: 13 points at d^2=16, 27 at d^2=17
        for (int k = 0; k < 40; k++) begin px[k] = 4'd9; py[k] = (k < 13) ? 4'd5 : 4'd6; end
        load_pts(40);
        set_c(4'd5, 4'd5, 4'd15, 4'd15);
        do_run(10);
        chk("cover_boundary", o_cover, 13);

        // Second-centre hits: (2,2) every sixth point, others (12,2)
        for (int k = 0; k < 40; k++) begin px[k] = (k % 6 == 0) ? 4'd2 : 4'd12; py[k] = 4'd2; end
        load_pts(40);
        set_c(4'd15, 4'd15, 4'd0, 4'd0);
        do_run(20);
        chk("cover_c2", o_cover, 7);
        chk("cycles_20", o_cycles, 20);

        // DONE raised while point 7 is on the bus
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        repeat (9) tick();
        chk("xy_point7", {o_x, o_y}, {px[7], py[7]});
        i_done = 1'b1;
        tick();
        i_done = 1'b0;
        chk("proto_res_valid", o_res_valid, 1);
        chk("proto_err", o_proto_err, 1);
        chk("proto_cover", o_cover, 0);
        tick();
        chk("proto_pulse_one", o_res_valid, 0);
        chk("proto_idle", o_busy, 0);
        chk("proto_hold", o_proto_err, 1);

`ifdef LASER_TIMEOUT_EN
        // Watchdog: no DONE, scoring uses the centres present at expiry
        do_run(-1);
        chk("wd_timeout", o_timeout, 1);
        chk("wd_cycles", o_cycles, 50);
        chk("wd_cover", o_cover, 7);
        chk("wd_proto", o_proto_err, 0);
`endif

        // All at (15,15), both centres at origin
        for (int k = 0; k < 40; k++) begin px[k] = 4'd15; py[k] = 4'd15; end
        load_pts(40);
        set_c(4'd0, 4'd0, 4'd0, 4'd0);
        do_run(5);
        chk("cover_far", o_cover, 0);

        // Reset during RUN
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        repeat (60) tick();
        chk("midrun_busy", o_busy, 1);
        rst = 1'b0;
        tick();
        chk("midrun_rst_busy", o_busy, 0);
        chk("midrun_rst_ready", o_ld_ready, 1);
        chk("midrun_rst_cycles", o_cycles, 0);
        rst = 1'b1;
        tick();
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        chk("start_after_rst_ignored", o_busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
